rom_read_arbiter: RTL and testbench

Sequencer and two-way arbiter that shares the single instruction/constant ROM between the instruction-fetch stage (IF) and the load stage (LS) of the multi-cycle CPU. It accepts one word-read request at a time, drives the ROM's active-low read enable and byte address, and waits a programmable number of cycles for the combinational read to settle. It then captures the big-endian 32-bit word and returns it to the requester with a one-cycle valid pulse. Misaligned or out-of-range addresses are rejected without touching the ROM.

---
 rtl/rom_read_arbiter_if.sv | 35 +++
 rtl/rom_read_arbiter.sv | 117 +++++++++++
 tb/tb_rom_read_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/rom_read_arbiter_if.sv
// Request/response bundle between the IF/LS requesters, the ROM arbiter and the ROM.
// The slave modport is the arbiter's view; master is the surrounding requesters and ROM.
interface rom_read_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic        if_valid;
    logic [31:0] if_data;
    logic        if_err;

    logic        ls_req;
    logic [31:0] ls_addr;
    logic        ls_ready;
    logic        ls_valid;
    logic [31:0] ls_data;
    logic        ls_err;

    logic        rom_nrd;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;

    modport slave (
        input  if_req, if_addr, ls_req, ls_addr, rom_data,
        output if_ready, if_valid, if_data, if_err,
        output ls_ready, ls_valid, ls_data, ls_err,
        output rom_nrd, rom_addr
    );

    modport master (
        output if_req, if_addr, ls_req, ls_addr, rom_data,
        input  if_ready, if_valid, if_data, if_err,
        input  ls_ready, ls_valid, ls_data, ls_err,
        input  rom_nrd, rom_addr
    );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one combinational ROM between instruction fetch and load.
// One word read in flight at a time; illegal addresses are answered with err and no ROM access.
module rom_read_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ROM_BYTES   = 100
) (
    input  logic              clk,
    input  logic              rst,
    rom_read_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [31:0] MAX_ADDR = 32'(ROM_BYTES - 4);
    // WAIT lasts WAIT_CYCLES cycles so valid lands at grant+WAIT_CYCLES+1; zero skips WAIT.
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_last, w_last_nxt;   // 1 = LS granted most recently
    logic        r_gnt, w_gnt_nxt;     // 1 = LS owns the current transaction
    logic        r_err, w_err_nxt;
    logic [31:0] r_addr, w_addr_nxt;

    logic        w_grant;
    logic        w_sel;
    logic        w_illegal;
    logic        w_rom_on;
    logic [31:0] w_req_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_gnt   <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_gnt   <= w_gnt_nxt;
            r_err   <= w_err_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    always_comb begin
        w_grant = 1'b0;
        w_sel   = 1'b0;
        if (bus.if_req && bus.ls_req) begin
            w_grant = 1'b1;
            w_sel   = ~r_last;
        end else if (bus.if_req) begin
            w_grant = 1'b1;
            w_sel   = 1'b0;
        end else if (bus.ls_req) begin
            w_grant = 1'b1;
            w_sel   = 1'b1;
        end
        // Ready is combinational, so mask it while reset is being applied.
        w_grant    = w_grant && (r_state == S_IDLE) && !rst;
        w_req_addr = w_sel ? bus.ls_addr : bus.if_addr;
        w_illegal  = (w_req_addr[1:0] != 2'b00) || (w_req_addr > MAX_ADDR);

        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_gnt_nxt   = r_gnt;
        w_err_nxt   = r_err;
        w_addr_nxt  = r_addr;

        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_last_nxt = w_sel;
                    w_gnt_nxt  = w_sel;
                    w_addr_nxt = w_req_addr;
                    w_err_nxt  = w_illegal;
                    w_cnt_nxt  = CNT_INIT;
                    if (w_illegal || WAIT_CYCLES == 0) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_rom_on     = (r_state == S_WAIT) || ((r_state == S_RESP) && !r_err);
        bus.rom_nrd  = ~w_rom_on;
        bus.rom_addr = w_rom_on ? r_addr : '0;

        bus.if_ready = w_grant && !w_sel;
        bus.ls_ready = w_grant && w_sel;

        bus.if_valid = (r_state == S_RESP) && !r_gnt;
        bus.ls_valid = (r_state == S_RESP) && r_gnt;
        bus.if_err   = bus.if_valid && r_err;
        bus.ls_err   = bus.ls_valid && r_err;
        bus.if_data  = (bus.if_valid && !r_err) ? bus.rom_data : '0;
        bus.ls_data  = (bus.ls_valid && !r_err) ? bus.rom_data : '0;
    end
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter: three instances (WAIT_CYCLES 1, 3, 0) share stimulus,
// a cycle-level scoreboard predicts grants, ROM strobes and responses of the selected one.
module tb_rom_read_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic        ls_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] ls_addr = '0;
    logic [7:0]  rom [0:99];
    int unsigned w = 1;

    always #5 clk = ~clk;

    rom_read_arbiter_if b1 ();
    rom_read_arbiter_if b3 ();
    rom_read_arbiter_if b0 ();

    rom_read_arbiter #(.WAIT_CYCLES(1), .ROM_BYTES(100)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    rom_read_arbiter #(.WAIT_CYCLES(3), .ROM_BYTES(100)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));
    rom_read_arbiter #(.WAIT_CYCLES(0), .ROM_BYTES(100)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

    assign b1.if_req = if_req;  assign b1.if_addr = if_addr;
    assign b1.ls_req = ls_req;  assign b1.ls_addr = ls_addr;
    assign b3.if_req = if_req;  assign b3.if_addr = if_addr;
    assign b3.ls_req = ls_req;  assign b3.ls_addr = ls_addr;
    assign b0.if_req = if_req;  assign b0.if_addr = if_addr;
    assign b0.ls_req = ls_req;  assign b0.ls_addr = ls_addr;

    assign b1.rom_data = (b1.rom_addr <= 32'd96) ? {rom[b1.rom_addr], rom[b1.rom_addr + 32'd1],
                          rom[b1.rom_addr + 32'd2], rom[b1.rom_addr + 32'd3]} : 32'hDEAD_BEEF;
    assign b3.rom_data = (b3.rom_addr <= 32'd96) ? {rom[b3.rom_addr], rom[b3.rom_addr + 32'd1],
                          rom[b3.rom_addr + 32'd2], rom[b3.rom_addr + 32'd3]} : 32'hDEAD_BEEF;
    assign b0.rom_data = (b0.rom_addr <= 32'd96) ? {rom[b0.rom_addr], rom[b0.rom_addr + 32'd1],
                          rom[b0.rom_addr + 32'd2], rom[b0.rom_addr + 32'd3]} : 32'hDEAD_BEEF;

    typedef struct packed {
        logic        if_ready;
        logic        if_valid;
        logic [31:0] if_data;
        logic        if_err;
        logic        ls_ready;
        logic        ls_valid;
        logic [31:0] ls_data;
        logic        ls_err;
        logic        nrd;
        logic [31:0] addr;
    } obs_t;

    obs_t o1, o3, o0, o;
    assign o1 = {b1.if_ready, b1.if_valid, b1.if_data, b1.if_err, b1.ls_ready, b1.ls_valid,
                 b1.ls_data, b1.ls_err, b1.rom_nrd, b1.rom_addr};
    assign o3 = {b3.if_ready, b3.if_valid, b3.if_data, b3.if_err, b3.ls_ready, b3.ls_valid,
                 b3.ls_data, b3.ls_err, b3.rom_nrd, b3.rom_addr};
    assign o0 = {b0.if_ready, b0.if_valid, b0.if_data, b0.if_err, b0.ls_ready, b0.ls_valid,
                 b0.ls_data, b0.ls_err, b0.rom_nrd, b0.rom_addr};
    assign o  = (w == 3) ? o3 : ((w == 0) ? o0 : o1);

    typedef struct {
        logic        ls;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        int          t_rdy;
        int          t_val;
    } entry_t;

    entry_t q[$];
    logic   glog[$];
    int     cyc = 0;
    int     m_free = 0;
    logic   m_last = 1'b1;
    int     n_checks = 0;
    int     n_err = 0;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        int i;
        if (a > 32'd96) return 32'hDEAD_BEEF;
        i = int'(a);
        return {rom[i], rom[i+1], rom[i+2], rom[i+3]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: sample at the falling edge against the model, then release granted requests.
    task automatic tick();
        logic   ex_on, eg, es, evv, ev_ls, rdy_if, rdy_ls;
        entry_t e;
        @(negedge clk);
        ex_on = (q.size() > 0) && !q[0].err && (cyc > q[0].t_rdy);
        check("rom_nrd", 32'(o.nrd), 32'(!ex_on));
        check("rom_addr", o.addr, ex_on ? q[0].addr : 32'd0);

        eg = !rst && (cyc >= m_free) && (if_req || ls_req);
        es = (if_req && ls_req) ? !m_last : ls_req;
        check("if_ready", 32'(o.if_ready), 32'(eg && !es));
        check("ls_ready", 32'(o.ls_ready), 32'(eg && es));

        evv   = (q.size() > 0) && (q[0].t_val == cyc);
        ev_ls = evv && q[0].ls;
        check("if_valid", 32'(o.if_valid), 32'(evv && !ev_ls));
        check("ls_valid", 32'(o.ls_valid), 32'(ev_ls));
        check("if_data", o.if_data, (evv && !ev_ls) ? q[0].data : 32'd0);
        check("ls_data", o.ls_data, ev_ls ? q[0].data : 32'd0);
        check("if_err", 32'(o.if_err), (evv && !ev_ls) ? 32'(q[0].err) : 32'd0);
        check("ls_err", 32'(o.ls_err), ev_ls ? 32'(q[0].err) : 32'd0);
        if (evv) void'(q.pop_front());

        rdy_if = o.if_ready;
        rdy_ls = o.ls_ready;
        if (rdy_if || rdy_ls) glog.push_back(rdy_ls);

        if (eg) begin
            e.ls    = es;
            e.addr  = es ? ls_addr : if_addr;
            e.err   = (e.addr[1:0] != 2'b00) || (e.addr > 32'd96);
            e.data  = e.err ? 32'd0 : rom_word(e.addr);
            e.t_rdy = cyc;
            e.t_val = cyc + (e.err ? 1 : int'(w) + 1);
            q.push_back(e);
            m_free = e.t_val + 1;
            m_last = es;
        end
        if (rst) begin
            q.delete();
            m_last = 1'b1;
            m_free = 0;
        end
        cyc++;
        @(posedge clk);
        #1;
        if (rdy_if) if_req = 1'b0;
        if (rdy_ls) ls_req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() > 0 || if_req || ls_req) && n < 200) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(n >= 200), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 100; i++) rom[i] = 8'(i * 29 + 7);
        rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'h56; rom[3] = 8'h78;

        // Reset with both requesters already waiting: IF wins the first tie.
        if_req = 1'b1; if_addr = 32'd4;
        ls_req = 1'b1; ls_addr = 32'd8;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        drain();

        if_req = 1'b1; if_addr = 32'd20;
        ls_req = 1'b1; ls_addr = 32'd24;
        tick();
        if_req = 1'b1; if_addr = 32'd28;
        drain();
        check("grant_count", 32'(glog.size()), 32'd5);
        for (int i = 0; i < 5 && i < glog.size(); i++)
            check($sformatf("grant_order[%0d]", i), 32'(glog[i]), 32'(i % 2));

        if_req = 1'b1; if_addr = 32'd0;
        drain();
        ls_req = 1'b1; ls_addr = 32'd6;
        drain();
        ls_req = 1'b1; ls_addr = 32'd97;
        drain();
        ls_req = 1'b1; ls_addr = 32'd96;
        drain();
        ls_req = 1'b1; ls_addr = 32'hFFFF_FFFC;
        drain();
        if_req = 1'b1; if_addr = 32'd2;
        drain();

        // WAIT_CYCLES=3 instance: reset during the second WAIT cycle aborts the read.
        rst = 1'b1;
        tick();
        w = 3;
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'd40;
        tick();
        tick();
        if_req = 1'b1; if_addr = 32'd44;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        drain();

        // WAIT_CYCLES=0 instance: back-to-back requests raised in the valid cycle.
        rst = 1'b1;
        tick();
        w = 0;
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'd12;
        tick();
        if_req = 1'b1; if_addr = 32'd16;
        drain();
        ls_req = 1'b1; ls_addr = 32'd96;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
